alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_op_decode.sv | 55 +++++
 rtl/alu_exec_unit.sv | 172 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encodings
// for the ALU execute unit.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_XOR    = 5'b00011,
        OP_SLL    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_SUB    = 5'b00110,
        OP_SLTU   = 5'b00111,
        OP_SLT    = 5'b01000,
        OP_SRA    = 5'b01001,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_code_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10
    } alu_state_t;

    // M-extension codes carry funct3 in their low bits
    function automatic alu_code_t mop_code(input logic [2:0] f3);
        return alu_code_t'({2'b10, f3});
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of alu_op/funct7/funct3
// into an internal op code plus illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output alu_code_t  code,
    output logic       illegal
);

    always_comb begin
        code    = OP_ADD;
        illegal = 1'b0;
        unique case (alu_op)
            2'b00: code = OP_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: code = OP_SUB;
                    3'b100, 3'b101: code = OP_SLT;
                    3'b110, 3'b111: code = OP_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            2'b10: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  code = OP_ADD;
                            3'b001:  code = OP_SLL;
                            3'b010:  code = OP_SLT;
                            3'b011:  code = OP_SLTU;
                            3'b100:  code = OP_XOR;
                            3'b101:  code = OP_SRL;
                            3'b110:  code = OP_OR;
                            default: code = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  code = OP_SUB;
                            3'b101:  code = OP_SRA;
                            default: illegal = 1'b1;
                        endcase
                    end
                    7'b0000001: code = mop_code(funct3);
                    default:    illegal = 1'b1;
                endcase
            end
            2'b11: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle integer ops plus
// iterative shift-add multiply and restoring divide.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SW = $clog2(XLEN);

    alu_state_t        state, state_nx;
    alu_code_t         code;
    logic              dec_ill, accept, is_m, last;
    logic [SW-1:0]     cnt;
    logic [SW-1:0]     shamt;
    logic [1:0]        msel;
    logic              neg, neg_nx;
    logic              a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0]   hi, lo, mcand;
    logic [XLEN-1:0]   mag_a, mag_b, alu_res;
    logic [XLEN-1:0]   step_hi, step_lo, dv, m_res;
    logic [XLEN:0]     sum, rs, diff;
    logic [2*XLEN-1:0] prod;

    alu_op_decode u_dec (
        .alu_op  (alu_op),
        .funct7  (funct7),
        .funct3  (funct3),
        .code    (code),
        .illegal (dec_ill)
    );

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_m     = !dec_ill && code[4];
    assign last     = (state != IDLE) && (cnt == SW'(XLEN - 1));
    assign shamt    = op_b[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (code)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            default: alu_res = '0;
        endcase
        if (dec_ill) alu_res = '0;
    end

    // Operate on magnitudes; sign is restored on the final step
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'b010:  a_sgn = 1'b1;
            default: begin end
        endcase
        sa    = a_sgn & op_a[XLEN-1];
        sb    = b_sgn & op_b[XLEN-1];
        mag_a = sa ? -op_a : op_a;
        mag_b = sb ? -op_b : op_b;
        if (!funct3[2])      neg_nx = sa ^ sb;
        else if (!funct3[1]) neg_nx = (sa ^ sb) & (op_b != '0);
        else                 neg_nx = sa;
    end

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        rs   = {hi, lo[XLEN-1]};
        diff = rs - {1'b0, mcand};
        if (state == DIV) begin
            step_hi = diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            step_hi = sum[XLEN:1];
            step_lo = {sum[0], lo[XLEN-1:1]};
        end
        prod = {step_hi, step_lo};
        if (neg) prod = -prod;
        dv = msel[1] ? step_hi : step_lo;
        if (neg) dv = -dv;
        if (state == DIV)       m_res = dv;
        else if (msel == 2'b00) m_res = prod[XLEN-1:0];
        else                    m_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && is_m) state_nx = code[2] ? DIV : MUL;
            end
            MUL, DIV: begin
                if (last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            neg       <= 1'b0;
            msel      <= 2'b00;
        end else begin
            if (accept && is_m) begin
                cnt   <= '0;
                hi    <= '0;
                lo    <= code[2] ? mag_a : mag_b;
                mcand <= code[2] ? mag_b : mag_a;
                neg   <= neg_nx;
                msel  <= code[1:0];
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
                hi  <= step_hi;
                lo  <= step_lo;
            end
            if (accept && !is_m) begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                illegal   <= dec_ill;
                out_valid <= 1'b1;
            end else if (last) begin
                result    <= m_res;
                zero      <= (m_res == '0);
                illegal   <= 1'b0;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed
// vectors queued on issue, checked by a monitor.
module tb_alu_exec_unit;

    localparam int XLEN = 32;
    localparam logic [1:0] LS = 2'b00;
    localparam logic [1:0] BR = 2'b01;
    localparam logic [1:0] RT = 2'b10;
    localparam logic [6:0] FZ = 7'h00;
    localparam logic [6:0] FS = 7'h20;
    localparam logic [6:0] FM = 7'h01;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b1;
    logic            in_ready, out_valid, zero, illegal;
    logic [1:0]      alu_op = '0;
    logic [6:0]      funct7 = '0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic [XLEN-1:0] result;

    typedef struct {
        string           name;
        logic [XLEN-1:0] res;
        logic            zf;
        logic            ill;
        int              lat;
        int              acc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   fresh = 1'b1;
    int   rise = 0;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct7    (funct7),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [XLEN-1:0] act,
                                input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endfunction

    // Monitor: pops an expectation on every output handshake
    always @(negedge clk) begin
        if (reset) begin
            fresh = 1'b1;
        end else if (out_valid) begin
            if (fresh) begin
                rise  = cyc;
                fresh = 1'b0;
            end
            if (out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected output: got 0x%0h, want none", result);
                end else begin
                    mon_e = sbq.pop_front();
                    chk({mon_e.name, " result"}, result, mon_e.res);
                    chk1({mon_e.name, " zero"}, zero, mon_e.zf);
                    chk1({mon_e.name, " illegal"}, illegal, mon_e.ill);
                    chk({mon_e.name, " latency"}, rise - mon_e.acc + 1, mon_e.lat);
                end
                fresh = 1'b1;
            end
        end
    end

    task automatic issue(input string nm, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] r,
                         input logic ill, input int lat, output int waits);
        exp_t e;
        alu_op   = op;
        funct7   = f7;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        waits    = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_ready && waits < 100);
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s accept: got no in_ready, want in_ready", nm);
        end else begin
            e.name = nm;
            e.res  = r;
            e.zf   = (r == '0);
            e.ill  = ill;
            e.lat  = lat;
            e.acc  = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Single-cycle op; must be accepted on the very next edge
    task automatic one(input string nm, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] r,
                       input logic ill);
        int w;
        issue(nm, op, f7, f3, a, b, r, ill, 1, w);
        chk({nm, " waits"}, w, 1);
    endtask

    task automatic mop(input string nm, input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] r);
        int w;
        issue(nm, RT, FM, f3, a, b, r, 1'b0, XLEN + 1, w);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt_hi;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("reset out_valid", out_valid, 1'b0);
        chk("reset result", result, '0);
        chk1("reset zero", zero, 1'b0);
        chk1("reset illegal", illegal, 1'b0);
        chk1("reset in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        one("add", RT, FZ, 3'b000, 5, 7, 12, 1'b0);
        one("beq", BR, FZ, 3'b000, 32'h1234, 32'h1234, 0, 1'b0);
        one("blt", BR, FZ, 3'b100, 32'hFFFFFFFF, 1, 1, 1'b0);
        one("bltu", BR, FZ, 3'b110, 32'hFFFFFFFF, 1, 0, 1'b0);
        one("br ill", BR, FZ, 3'b010, 9, 3, 0, 1'b1);
        one("op11 ill", 2'b11, FZ, 3'b000, 9, 3, 0, 1'b1);
        one("sub", RT, FS, 3'b000, 3, 5, 32'hFFFFFFFE, 1'b0);
        one("and", RT, FZ, 3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        one("or", RT, FZ, 3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
        one("xor", RT, FZ, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
        one("sll", RT, FZ, 3'b001, 1, 32'h21, 2, 1'b0);
        one("srl", RT, FZ, 3'b101, 32'h80000000, 4, 32'h08000000, 1'b0);
        one("sra", RT, FS, 3'b101, 32'h80000000, 4, 32'hF8000000, 1'b0);
        one("slt", RT, FZ, 3'b010, 32'hFFFFFFFB, 3, 1, 1'b0);
        one("sltu", RT, FZ, 3'b011, 32'hFFFFFFFB, 3, 0, 1'b0);
        one("f7s ill", RT, FS, 3'b001, 1, 1, 0, 1'b1);
        one("f7 ill", RT, 7'h7F, 3'b000, 1, 1, 0, 1'b1);
        one("ls add", LS, 7'h55, 3'b011, 32'h1000, 32'hFFFFFFFC, 32'h00000FFC, 1'b0);
        drain();

        mop("mul", 3'b000, 32'hFFFFFFFD, 7, 32'hFFFFFFEB);
        cnt_hi = 0;
        repeat (XLEN) begin
            @(negedge clk);
            if (in_ready) cnt_hi++;
        end
        chk("mul busy in_ready", cnt_hi, 0);
        mop("mulh", 3'b001, 32'hFFFFFFFD, 7, 32'hFFFFFFFF);
        mop("mulhu", 3'b011, 32'hFFFFFFFD, 7, 6);
        mop("mulhsu", 3'b010, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF);
        mop("mulhu big", 3'b011, 32'hFFFFFFFE, 32'h80000000, 32'h7FFFFFFF);
        mop("divu /0", 3'b101, 10, 0, 32'hFFFFFFFF);
        mop("remu /0", 3'b111, 10, 0, 10);
        mop("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        mop("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 0);
        mop("div neg", 3'b100, 32'hFFFFFFF9, 2, 32'hFFFFFFFD);
        mop("rem neg", 3'b110, 32'hFFFFFFF9, 2, 32'hFFFFFFFF);
        mop("div /0", 3'b100, 32'hFFFFFFF6, 0, 32'hFFFFFFFF);
        mop("rem /0", 3'b110, 32'hFFFFFFF6, 0, 32'hFFFFFFF6);
        mop("divu", 3'b101, 100, 7, 14);
        mop("remu", 3'b111, 100, 7, 2);
        drain();

        out_ready = 1'b0;
        issue("hold add", RT, FZ, 3'b000, 1, 1, 2, 1'b0, 1, w);
        repeat (3) begin
            @(negedge clk);
            chk1("hold out_valid", out_valid, 1'b1);
            chk("hold result", result, 2);
            chk1("hold in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue("post-hold add", RT, FZ, 3'b000, 3, 4, 7, 1'b0, 1, w);
        chk("post-hold waits", w, 1);
        drain();

        mop("div abort", 3'b100, 100, 7, 14);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        chk1("abort out_valid", out_valid, 1'b0);
        chk("abort result", result, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("post-reset in_ready", in_ready, 1'b1);
        cnt_hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt_hi++;
        end
        chk("no stale result", cnt_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
